// File: rtl/tdc_meas_ctrl_pkg.sv
// Shared definitions for the TDC measurement sequencer: result word width,
// FSM state encoding and the CLEAR hold length.
package tdc_meas_ctrl_pkg;

    // Width of the TDC result word
    localparam int TDC_DIG_OUT = 32;

    // Cycles spent in CLEAR, covering the TDC's two-flop ready delay
    localparam int CLEAR_CYCLES = 2;
    localparam int CLR_W        = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ARMED = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage : tdc_meas_ctrl_pkg

// File: rtl/tdc_result_fifo.sv
// Synchronous result FIFO with a registered head word. Pointers carry one
// extra bit so full and empty can be told apart. A word pushed into an empty
// FIFO reaches the head one cycle later.
module tdc_result_fifo #(
    parameter int DIG_OUT    = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               push,
    input  logic [DIG_OUT-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [DIG_OUT-1:0] head
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DIG_OUT-1:0] mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic [AW:0]        wr_next, rd_next;
    logic               push_eff, pop_eff;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);
    assign rd_next  = rd_ptr + (AW+1)'(pop_eff);
    assign wr_next  = wr_ptr + (AW+1)'(push_eff);

    // Pointer update; clear empties the FIFO in one cycle
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
        end
    end

    // Storage write
    // NOTE: the array is not reset; only pointers define validity, so storage stays plain RAM.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Registered head: bypass the pushed word when it becomes the head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
        end else if (clear) begin
            head <= '0;
        end else if (push_eff && (wr_ptr == rd_next)) begin
            head <= push_data;
        end else if (rd_next != wr_ptr) begin
            head <= mem[rd_next[AW-1:0]];
        end
    end

endmodule : tdc_result_fifo

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: arms the TDC for a burst of hits, buffers each
// result in tdc_result_fifo and streams it out over valid/ready.
// Optional watchdog: define TDC_CTRL_TIMEOUT_EN to build the re-arm timer;
// without it ARMED waits for a hit indefinitely and oTimeoutErr is 0.
module tdc_meas_ctrl
    import tdc_meas_ctrl_pkg::*;
#(
    parameter int DIG_OUT    = TDC_DIG_OUT,
    parameter int FIFO_DEPTH = 8,
    parameter int BURST_W    = 16,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iStart,
    input  logic                 iAbort,
    input  logic [BURST_W-1:0]   iBurstLen,
    input  logic [TIMEOUT_W-1:0] iTimeout,
    output logic                 oTdcEnable,
    output logic                 oTdcRst,
    input  logic                 iTdcDone,
    input  logic [DIG_OUT-1:0]   iTdcData,
    output logic [DIG_OUT-1:0]   oData,
    output logic                 oValid,
    input  logic                 iReady,
    output logic                 oBusy,
    output logic [BURST_W-1:0]   oCount,
    output logic                 oOverflow,
    output logic                 oTimeoutErr
);

    state_e             state, next_state;
    logic [CLR_W-1:0]   clr_cnt;
    logic [BURST_W-1:0] burst_len_q;
    logic [BURST_W-1:0] count_inc;
    logic               fifo_full, fifo_empty;
    logic               push, drop, pop, start_ok;
    logic               wd_expire;

    assign pop        = oValid && iReady;
    assign oValid     = !fifo_empty;
    assign count_inc  = oCount + 1'b1;
    assign oBusy      = (state != IDLE);
    assign oTdcEnable = (state == ARMED);
    assign oTdcRst    = (state != ARMED);

    // Next-state and per-cycle strobes; abort > hit > watchdog
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        next_state = state;
        push       = 1'b0;
        drop       = 1'b0;
        start_ok   = 1'b0;
        if (iAbort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        start_ok   = 1'b1;
                        next_state = CLEAR;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) next_state = ARMED;
                end
                ARMED: begin
                    if (iTdcDone) begin
                        if (!fifo_full || pop) begin
                            push = 1'b1;
                            if ((burst_len_q != '0) && (count_inc == burst_len_q)) next_state = DRAIN;
                        end else begin
                            drop = 1'b1;
                        end
                    end else if (wd_expire) begin
                        next_state = CLEAR;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // State register and CLEAR hold counter
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= next_state;
            clr_cnt <= (state == CLEAR && next_state == CLEAR) ? clr_cnt + 1'b1 : '0;
        end
    end

    // Burst length latch, result counter and sticky overflow flag
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            burst_len_q <= '0;
            oCount      <= '0;
            oOverflow   <= 1'b0;
        end else if (start_ok) begin
            burst_len_q <= iBurstLen;
            oCount      <= '0;
            oOverflow   <= 1'b0;
        end else begin
            if (push) oCount    <= count_inc;
            if (drop) oOverflow <= 1'b1;
        end
    end

`ifdef TDC_CTRL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timeout_q, wd_cnt;
    logic                 timeout_hit;

    assign wd_expire   = (timeout_q != '0) && (wd_cnt == timeout_q);
    assign timeout_hit = (state == ARMED) && (next_state == CLEAR);

    // Watchdog: restarts on entry to ARMED and on every accepted hit
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            timeout_q   <= '0;
            wd_cnt      <= '0;
            oTimeoutErr <= 1'b0;
        end else begin
            if (start_ok) timeout_q <= iTimeout;
            if (state != ARMED || push) wd_cnt <= '0;
            else                        wd_cnt <= wd_cnt + 1'b1;
            if (start_ok)         oTimeoutErr <= 1'b0;
            else if (timeout_hit) oTimeoutErr <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^iTimeout;
    assign wd_expire      = 1'b0;
    assign oTimeoutErr    = 1'b0;
`endif

    tdc_result_fifo #(
        .DIG_OUT    (DIG_OUT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (iClk),
        .rst_n     (iRst_n),
        .clear     (iAbort),
        .push      (push),
        .push_data (iTdcData),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (oData)
    );

endmodule : tdc_meas_ctrl

// File: tb/tb_tdc_meas_ctrl.sv
// Self-checking bench for tdc_meas_ctrl: a scoreboard queue holds expected
// result words, a monitor pops and compares on every stream handshake, and
// directed checks cover control outputs.
module tb_tdc_meas_ctrl;

    localparam int DW = 32;
    localparam int BW = 16;
    localparam int TW = 16;

    logic          iClk, iRst_n, iStart, iAbort, iTdcDone, iReady;
    logic [BW-1:0] iBurstLen;
    logic [TW-1:0] iTimeout;
    logic [DW-1:0] iTdcData;
    logic          oTdcEnable, oTdcRst, oValid, oBusy, oOverflow, oTimeoutErr;
    logic [DW-1:0] oData;
    logic [BW-1:0] oCount;

    logic [DW-1:0] exp_q [$];
    int            compared   = 0;
    int            mismatched = 0;

    tdc_meas_ctrl dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iStart      (iStart),
        .iAbort      (iAbort),
        .iBurstLen   (iBurstLen),
        .iTimeout    (iTimeout),
        .oTdcEnable  (oTdcEnable),
        .oTdcRst     (oTdcRst),
        .iTdcDone    (iTdcDone),
        .iTdcData    (iTdcData),
        .oData       (oData),
        .oValid      (oValid),
        .iReady      (iReady),
        .oBusy       (oBusy),
        .oCount      (oCount),
        .oOverflow   (oOverflow),
        .oTimeoutErr (oTimeoutErr)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must present the oldest expected word
    always @(negedge iClk) begin
        if (iRst_n && oValid && iReady) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_word: got %h expected none", oData);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (oData !== e) begin
                    mismatched++;
                    $display("FAIL stream_word: got %h expected %h", oData, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic start_burst(input logic [BW-1:0] len, input logic [TW-1:0] tmo);
        iBurstLen = len;
        iTimeout  = tmo;
        iStart    = 1'b1;
        tick();
        iStart    = 1'b0;
    endtask

    task automatic hit(input logic [DW-1:0] d, input bit expect_push);
        iTdcData = d;
        iTdcDone = 1'b1;
        if (expect_push) exp_q.push_back(d);
        tick();
        iTdcDone = 1'b0;
    endtask

    task automatic do_abort();
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (oBusy && n < budget) begin
            tick();
            n++;
        end
        check(name, {31'd0, oBusy}, 32'd0);
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (oValid && n < budget) begin
            tick();
            n++;
        end
        check(name, {31'd0, oValid}, 32'd0);
    endtask

    initial begin
        iRst_n = 1'b0; iStart = 1'b0; iAbort = 1'b0; iTdcDone = 1'b0; iReady = 1'b0;
        iBurstLen = '0; iTimeout = '0; iTdcData = '0;
        #12;
        check("rst_tdc_rst",    {31'd0, oTdcRst},     32'd1);
        check("rst_enable",     {31'd0, oTdcEnable},  32'd0);
        check("rst_valid",      {31'd0, oValid},      32'd0);
        check("rst_data",       oData,                32'd0);
        check("rst_busy",       {31'd0, oBusy},       32'd0);
        check("rst_count",      {16'd0, oCount},      32'd0);
        check("rst_overflow",   {31'd0, oOverflow},   32'd0);
        check("rst_timeouterr", {31'd0, oTimeoutErr}, 32'd0);
        iRst_n = 1'b1;
        tick();

        // Normal burst of three
        iReady = 1'b1;
        start_burst(16'd3, 16'd0);
        check("clear1_busy",   {31'd0, oBusy},      32'd1);
        check("clear1_enable", {31'd0, oTdcEnable}, 32'd0);
        tick();
        check("clear2_tdc_rst", {31'd0, oTdcRst},   32'd1);
        tick();
        check("armed_enable",  {31'd0, oTdcEnable}, 32'd1);
        check("armed_tdc_rst", {31'd0, oTdcRst},    32'd0);
        hit(32'h11, 1'b1);
        check("burst_valid",   {31'd0, oValid},     32'd1);
        check("burst_count1",  {16'd0, oCount},     32'd1);
        tick();
        hit(32'h22, 1'b1);
        tick();
        hit(32'h33, 1'b1);
        check("burst_count3",  {16'd0, oCount},     32'd3);
        check("drain_enable",  {31'd0, oTdcEnable}, 32'd0);
        wait_idle("burst_idle", 10);
        check("burst_queue",   exp_q.size(),        32'd0);
        check("burst_count_end", {16'd0, oCount},   32'd3);

        // Overflow: 10 hits into an 8-deep FIFO with no reader
        iReady = 1'b0;
        start_burst(16'd0, 16'd0);
        tick(); tick();
        for (int i = 0; i < 10; i++) hit(32'h100 + i, i < 8);
        check("ovf_flag",  {31'd0, oOverflow}, 32'd1);
        check("ovf_count", {16'd0, oCount},    32'd8);
        check("ovf_busy",  {31'd0, oBusy},     32'd1);
        iReady = 1'b1;
        wait_empty("ovf_drain", 20);
        check("ovf_queue", exp_q.size(), 32'd0);
        iReady = 1'b0;
        do_abort();
        check("abort1_busy",  {31'd0, oBusy},     32'd0);
        check("abort1_count", {16'd0, oCount},    32'd8);
        check("abort1_ovf",   {31'd0, oOverflow}, 32'd1);

        // Full FIFO with a simultaneous pop: push must be accepted
        start_burst(16'd0, 16'd0);
        check("restart_count", {16'd0, oCount},    32'd0);
        check("restart_ovf",   {31'd0, oOverflow}, 32'd0);
        tick(); tick();
        for (int i = 0; i < 8; i++) hit(32'h200 + i, 1'b1);
        check("full_count", {16'd0, oCount}, 32'd8);
        iReady = 1'b1;
        hit(32'hAA, 1'b1);
        iReady = 1'b0;
        check("simul_ovf",   {31'd0, oOverflow}, 32'd0);
        check("simul_count", {16'd0, oCount},    32'd9);
        iReady = 1'b1;
        wait_empty("simul_drain", 20);
        check("simul_queue", exp_q.size(), 32'd0);
        iReady = 1'b0;
        do_abort();

        // Abort mid-burst with two words queued
        start_burst(16'd5, 16'd0);
        tick(); tick();
        hit(32'h301, 1'b1);
        hit(32'h302, 1'b1);
        check("abort_pre_count", {16'd0, oCount}, 32'd2);
        do_abort();
        exp_q.delete();
        check("abort_busy",  {31'd0, oBusy},  32'd0);
        check("abort_valid", {31'd0, oValid}, 32'd0);
        check("abort_count", {16'd0, oCount}, 32'd2);
        iReady = 1'b1;
        start_burst(16'd1, 16'd0);
        check("abort_restart_count", {16'd0, oCount}, 32'd0);
        tick(); tick();
        hit(32'h55, 1'b1);
        wait_idle("len1_idle", 10);
        check("len1_queue", exp_q.size(), 32'd0);

        // Watchdog with no hits
        start_burst(16'd0, 16'd20);
`ifdef TDC_CTRL_TIMEOUT_EN
        begin
            int n = 0;
            while (!oTimeoutErr && n < 40) begin
                tick();
                n++;
            end
            check("wd_latency", n, 32'd23);
            check("wd_clear1", {31'd0, oTdcRst}, 32'd1);
            tick();
            check("wd_clear2", {31'd0, oTdcRst}, 32'd1);
            tick();
            check("wd_rearm", {31'd0, oTdcEnable}, 32'd1);
        end
`else
        for (int i = 0; i < 40; i++) tick();
        check("nowd_err",    {31'd0, oTimeoutErr}, 32'd0);
        check("nowd_enable", {31'd0, oTdcEnable},  32'd1);
`endif
        do_abort();

        // Asynchronous reset while ARMED with data queued
        iReady = 1'b0;
        start_burst(16'd0, 16'd0);
        tick(); tick();
        hit(32'h401, 1'b1);
        hit(32'h402, 1'b1);
        #2 iRst_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_tdc_rst",  {31'd0, oTdcRst},    32'd1);
        check("arst_enable",   {31'd0, oTdcEnable}, 32'd0);
        check("arst_valid",    {31'd0, oValid},     32'd0);
        check("arst_data",     oData,               32'd0);
        check("arst_busy",     {31'd0, oBusy},      32'd0);
        check("arst_count",    {16'd0, oCount},     32'd0);
        check("arst_overflow", {31'd0, oOverflow},  32'd0);
        tick();
        iRst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_tdc_meas_ctrl

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer for the TDC core. It arms the TDC for a programmed burst of hits and captures each result when the TDC pulses done. Results are buffered in a small FIFO and handed to the readout side over a valid/ready stream. A watchdog re-arms the TDC if no hit arrives in time. The block runs on the same clock as the TDC's clk0 and drives the TDC enable and reset pins.

## Interface
- DIG_OUT, 32, width of the TDC result word (value comes from the shared defines)
- FIFO_DEPTH, 8, result buffer depth in words; must be a power of two and at least 2
- BURST_W, 16, width of the burst length and measurement counter
- TIMEOUT_W, 16, width of the watchdog counter

- iClk  in  1  system clock, same net as the TDC clk0
- iRst_n  in  1  asynchronous reset, active-low
- iStart  in  1  single-cycle pulse that begins a burst; honoured only in IDLE
- iAbort  in  1  level; forces IDLE from any state and empties the FIFO
- iBurstLen  in  BURST_W  number of results per burst; 0 means continuous; sampled on an accepted iStart
- iTimeout  in  TIMEOUT_W  watchdog limit in cycles; 0 disables the watchdog; sampled on an accepted iStart
- oTdcEnable  out  1  drives TDC enable
- oTdcRst  out  1  drives TDC iRst
- iTdcDone  in  1  TDC done pulse
- iTdcData  in  DIG_OUT  TDC oTDC word, valid while iTdcDone=1
- oData  out  DIG_OUT  result at the FIFO head
- oValid  out  1  FIFO not empty
- iReady  in  1  consumer accepts oData
- oBusy  out  1  high in every state except IDLE
- oCount  out  BURST_W  results accepted in the current burst
- oOverflow  out  1  sticky; a result was dropped because the FIFO was full
- oTimeoutErr  out  1  sticky; the watchdog expired

## Operation
- **IDLE**: oTdcRst=1, oTdcEnable=0. An iStart pulse latches iBurstLen and iTimeout, clears oCount and both sticky flags, then moves to CLEAR.
- **CLEAR**: oTdcRst=1, oTdcEnable=0 for exactly 2 cycles, covering the TDC's two-flop ready delay. Then moves to ARMED.
- **ARMED**: oTdcRst=0, oTdcEnable=1; the watchdog counts up every cycle.
  - On iTdcDone, if the FIFO has room (or a pop happens in the same cycle): push iTdcData, increment oCount, clear the watchdog.
  - On iTdcDone with the FIFO full and no pop: drop the word, set oOverflow, leave oCount unchanged.
  - When an accepted push makes oCount equal the latched burst length (nonzero): move to DRAIN.
  - Continuous mode (burst length 0): oCount wraps modulo 2^BURST_W and the block stays ARMED.
- **DRAIN**: oTdcEnable=0, oTdcRst=1. Moves to IDLE on the first cycle the FIFO is empty.
- **Priority within a cycle**: iAbort, then iTdcDone, then watchdog expiry. iAbort moves to IDLE in the next cycle and clears the FIFO pointers; oCount and the sticky flags keep their values.
- The TDC clears itself after done, so no CLEAR visit is needed between hits.

## Timing
- Reset values: oTdcRst=1, oTdcEnable=0, oValid=0, oData=0, oBusy=0, oCount=0, oOverflow=0, oTimeoutErr=0.
- iStart in cycle T: CLEAR in T+1 and T+2; oTdcEnable=1 from T+3.
- iTdcDone in cycle T: oValid=1 and oCount updated in T+1. Push-to-head latency is 1 cycle.
- A pop happens in the cycle where oValid and iReady are both 1. oData is registered from the FIFO head and shows the next word in the following cycle. Full throughput is one word per cycle.
- Watchdog: expiry when the counter equals the latched iTimeout. In that cycle oTimeoutErr is set and the state moves to CLEAR (TDC re-armed, nothing pushed). The counter clears on entry to ARMED.
- oBusy goes low in the same cycle the state becomes IDLE.

## Configuration
- **TDC_CTRL_TIMEOUT_EN defined**: watchdog counter and expiry logic are present as described above.
- **TDC_CTRL_TIMEOUT_EN undefined**:
  - no counter is built and iTimeout is unused;
  - oTimeoutErr is tied to 0;
  - ARMED waits for iTdcDone indefinitely.

## Structure
- The shared defines file holds DIG_OUT, the state encoding constants (IDLE, CLEAR, ARMED, DRAIN) and the CLEAR hold length (2).
- One sub-module, tdc_result_fifo:
  - synchronous FIFO with asynchronous active-low reset;
  - push/pop/full/empty ports and a registered head;
  - parameters DIG_OUT and FIFO_DEPTH;
  - pointers one bit wider than log2(FIFO_DEPTH) to tell full from empty.
- The FSM, counters and sticky flags live in tdc_meas_ctrl.

## Test plan
- **Normal burst**: iBurstLen=3, iReady=1, three iTdcDone with data 0x11/0x22/0x33 → the same three words appear in order; oCount=3; state passes through DRAIN to IDLE; oBusy falls once the FIFO is empty.
- **Overflow**: FIFO_DEPTH=8, iReady=0, iBurstLen=0, 10 done pulses → first 8 words stored, oOverflow=1, oCount=8. Then iReady=1 → exactly 8 words read.
- **Full FIFO with simultaneous pop**: FIFO full, iTdcDone and a pop in the same cycle → push accepted, oOverflow stays 0.
- **Watchdog** (TDC_CTRL_TIMEOUT_EN defined): iTimeout=20, no hit → oTimeoutErr=1 about 20 cycles after ARMED, followed by 2 cycles of oTdcRst=1 and then re-arm. Without the macro, oTimeoutErr stays 0 and the block stays ARMED.
- **Abort**: iAbort asserted mid-burst with 2 words queued → IDLE in the next cycle, oValid=0, oCount unchanged. A later iStart clears oCount.
- **Reset**: iRst_n asserted in ARMED with the FIFO non-empty → every output returns to its reset value immediately (asynchronously).
